// File: rtl/wbgpio_ctl.sv
// Wishbone GPIO controller: OUT/SET/CLR/DIR registers plus synchronised inputs
// with per-pin rise/fall interrupt enables and a sticky write-one-to-clear status.
module wbgpio_ctl #(
   parameter int             NIO         = 16,
   parameter logic [NIO-1:0] DEFAULT_OUT = '0,
   parameter logic [NIO-1:0] DEFAULT_DIR = '0
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_wb_cyc,
   input  logic           i_wb_stb,
   input  logic           i_wb_we,
   input  logic [2:0]     i_wb_addr,
   input  logic [31:0]    i_wb_data,
   input  logic [3:0]     i_wb_sel,
   output logic           o_wb_stall,
   output logic           o_wb_ack,
   output logic [31:0]    o_wb_data,
   input  logic [NIO-1:0] i_gpio,
   output logic [NIO-1:0] o_gpio,
   output logic [NIO-1:0] o_gpio_oe,
   output logic           o_int
);

   typedef enum logic [2:0] {
      A_IN   = 3'd0,
      A_OUT  = 3'd1,
      A_SET  = 3'd2,
      A_CLR  = 3'd3,
      A_DIR  = 3'd4,
      A_RISE = 3'd5,
      A_FALL = 3'd6,
      A_ISR  = 3'd7
   } addr_e;

   logic [NIO-1:0] out_q, out_d;
   logic [NIO-1:0] dir_q, dir_d;
   logic [NIO-1:0] rise_en_q, rise_en_d;
   logic [NIO-1:0] fall_en_q, fall_en_d;
   logic [NIO-1:0] isr_q, isr_d;
   logic [NIO-1:0] sync1_q, sync1_d;
   logic [NIO-1:0] sync2_q, sync2_d;
   logic [NIO-1:0] sync3_q, sync3_d;
   logic [1:0]     warm_q, warm_d;
   logic           ack_q, ack_d;
   logic           int_q, int_d;
   logic [31:0]    rdata_q, rdata_d;

   logic           req;
   logic           wr;
   addr_e          addr;
   logic [31:0]    byte_mask;
   logic [NIO-1:0] wmask;
   logic [NIO-1:0] wdata;
   logic [NIO-1:0] w1c;
   logic [NIO-1:0] ev_rise;
   logic [NIO-1:0] ev_fall;
   logic           warmed;
   logic           unused_bits;

   assign unused_bits = ^{i_wb_data, byte_mask};

   // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
   always_comb begin
      req  = i_wb_stb & i_wb_cyc;
      wr   = req & i_wb_we;
      addr = addr_e'(i_wb_addr);

      for (int i = 0; i < 32; i++) byte_mask[i] = i_wb_sel[i/8];
      wmask = byte_mask[NIO-1:0];
      wdata = i_wb_data[NIO-1:0];

      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c       = '0;

      if (wr) begin
         case (addr)
            A_OUT:   out_d     = (out_q & ~wmask) | (wdata & wmask);
            A_SET:   out_d     = out_q | (wdata & wmask);
            A_CLR:   out_d     = out_q & ~(wdata & wmask);
            A_DIR:   dir_d     = (dir_q & ~wmask) | (wdata & wmask);
            A_RISE:  rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
            A_FALL:  fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
            A_ISR:   w1c       = wdata & wmask;
            default: ;
         endcase
      end

      sync1_d = i_gpio;
      sync2_d = sync1_q;
      sync3_d = sync2_q;

      // Reset-zeroed stages would look like edges; hold them off until the pipe is full.
      warmed  = (warm_q == 2'd3);
      warm_d  = warmed ? warm_q : warm_q + 2'd1;
      ev_rise = warmed ? (sync2_q & ~sync3_q & rise_en_q) : '0;
      ev_fall = warmed ? (~sync2_q & sync3_q & fall_en_q) : '0;

      // New events are OR-ed in after the clear, so an event beats a same-cycle W1C.
      isr_d = (isr_q & ~w1c) | ev_rise | ev_fall;
      int_d = |isr_q;
      ack_d = req;

      rdata_d = rdata_q;
      if (req) begin
         case (addr)
            A_IN:    rdata_d = 32'(sync2_q);
            A_OUT:   rdata_d = 32'(out_q);
            A_DIR:   rdata_d = 32'(dir_q);
            A_RISE:  rdata_d = 32'(rise_en_q);
            A_FALL:  rdata_d = 32'(fall_en_q);
            A_ISR:   rdata_d = 32'(isr_q);
            default: rdata_d = '0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         out_q     <= DEFAULT_OUT;
         dir_q     <= DEFAULT_DIR;
         rise_en_q <= '0;
         fall_en_q <= '0;
         isr_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         sync3_q   <= '0;
         warm_q    <= '0;
         ack_q     <= 1'b0;
         int_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         isr_q     <= isr_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         sync3_q   <= sync3_d;
         warm_q    <= warm_d;
         ack_q     <= ack_d;
         int_q     <= int_d;
         rdata_q   <= rdata_d;
      end
   end

   assign o_wb_stall = 1'b0;
   assign o_wb_ack   = ack_q;
   assign o_wb_data  = rdata_q;
   assign o_gpio     = out_q;
   assign o_gpio_oe  = dir_q;
   assign o_int      = int_q;

endmodule

// File: tb/tb_wbgpio_ctl.sv
// Bench for wbgpio_ctl: table of bus vectors plus hand-written edge/interrupt
// sequences; read data is checked through a scoreboard queue popped on each ack.
module tb_wbgpio_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_wb_cyc = 1'b0;
   logic        i_wb_stb = 1'b0;
   logic        i_wb_we = 1'b0;
   logic [2:0]  i_wb_addr = '0;
   logic [31:0] i_wb_data = '0;
   logic [3:0]  i_wb_sel = '0;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;
   logic [15:0] i_gpio = '0;
   logic [15:0] o_gpio;
   logic [15:0] o_gpio_oe;
   logic        o_int;

   wbgpio_ctl #(
      .NIO(16),
      .DEFAULT_OUT(16'h00A5),
      .DEFAULT_DIR(16'h00FF)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_wb_cyc(i_wb_cyc),
      .i_wb_stb(i_wb_stb),
      .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr),
      .i_wb_data(i_wb_data),
      .i_wb_sel(i_wb_sel),
      .o_wb_stall(o_wb_stall),
      .o_wb_ack(o_wb_ack),
      .o_wb_data(o_wb_data),
      .i_gpio(i_gpio),
      .o_gpio(o_gpio),
      .o_gpio_oe(o_gpio_oe),
      .o_int(o_int)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          chk;
      logic [31:0] exp;
   } sb_t;

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   sb_t  sb[$];
   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   logic exp_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bus cycle; consecutive calls produce back-to-back strobes.
   task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp, input bit push);
      sb_t e;
      i_wb_cyc  = 1'b1;
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = a;
      i_wb_data = d;
      i_wb_sel  = s;
      if (push) begin
         e.chk = !we;
         e.exp = exp;
         sb.push_back(e);
      end
      tick();
      i_wb_cyc = 1'b0;
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      bus(1'b1, a, d, s, 32'h0, 1'b1);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp);
      bus(1'b0, a, 32'h0, 4'hF, exp, 1'b1);
   endtask

   always @(posedge clk) exp_ack <= i_wb_stb & i_wb_cyc & ~rst;

   always @(negedge clk) begin
      sb_t e;
      if (mon_en) begin
         check("ack", 32'(o_wb_ack), 32'(exp_ack));
         if (i_wb_stb) check("stall", 32'(o_wb_stall), 32'h0);
         if (o_wb_ack) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
            end else begin
               e = sb.pop_front();
               if (e.chk) check("rdata", o_wb_data, e.exp);
            end
         end
      end
   end

   initial begin
      vecs.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_00A5});
      vecs.push_back('{1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_00FF});
      vecs.push_back('{1'b0, 3'd7, 32'h0, 4'hF, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'd2, 32'h0, 4'hF, 32'h0000_0000});
      vecs.push_back('{1'b1, 3'd2, 32'h0000_0100, 4'hF, 32'h0});
      vecs.push_back('{1'b1, 3'd3, 32'h0000_0001, 4'hF, 32'h0});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_01A4});
      vecs.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 4'b0001, 32'h0});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_01FF});
      vecs.push_back('{1'b1, 3'd1, 32'hABCD_5A5A, 4'b0011, 32'h0});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_5A5A});
      vecs.push_back('{1'b1, 3'd3, 32'h0000_FFFF, 4'b0010, 32'h0});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_005A});
      vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0100, 32'h0});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_005A});
      vecs.push_back('{1'b0, 3'd3, 32'h0, 4'hF, 32'h0000_0000});
      vecs.push_back('{1'b1, 3'd4, 32'h0000_1234, 4'hF, 32'h0});
      vecs.push_back('{1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_1234});
      vecs.push_back('{1'b1, 3'd5, 32'h0000_0001, 4'hF, 32'h0});
      vecs.push_back('{1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_0001});
      vecs.push_back('{1'b1, 3'd6, 32'hFFFF_8000, 4'hF, 32'h0});
      vecs.push_back('{1'b0, 3'd6, 32'h0, 4'hF, 32'h0000_8000});
      vecs.push_back('{1'b0, 3'd0, 32'h0, 4'hF, 32'h0000_0000});

      // Reset, with a write issued during the last reset cycle that must be discarded.
      tick();
      mon_en = 1'b1;
      tick();
      bus(1'b1, 3'd1, 32'h0000_1234, 4'hF, 32'h0, 1'b0);
      rst = 1'b0;
      check("rst_gpio", 32'(o_gpio), 32'h0000_00A5);
      check("rst_oe", 32'(o_gpio_oe), 32'h0000_00FF);
      check("rst_int", 32'(o_int), 32'h0);

      foreach (vecs[i]) bus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, vecs[i].exp, 1'b1);
      tick();
      check("gpio_out", 32'(o_gpio), 32'h0000_005A);
      check("gpio_oe", 32'(o_gpio_oe), 32'h0000_1234);

      // Rising edge on pin 0: IN visible after 2 edges, ISR at +3, o_int at +4.
      i_gpio[0] = 1'b1;
      rd(3'd0, 32'h0000_0000);
      rd(3'd0, 32'h0000_0000);
      rd(3'd0, 32'h0000_0001);
      check("int_before", 32'(o_int), 32'h0);
      rd(3'd7, 32'h0000_0001);
      check("int_rise", 32'(o_int), 32'h1);
      wr(3'd7, 32'h0000_0001, 4'hF);
      check("int_w1c_hold", 32'(o_int), 32'h1);
      tick();
      check("int_w1c_clear", 32'(o_int), 32'h0);
      rd(3'd7, 32'h0000_0000);

      // Falling edge on pin 15 sets ISR[15].
      i_gpio[15] = 1'b1;
      repeat (4) tick();
      i_gpio[15] = 1'b0;
      repeat (4) tick();
      check("int_fall", 32'(o_int), 32'h1);
      rd(3'd7, 32'h0000_8000);

      // Second fall lands in the same cycle as a W1C of bit 15: the event wins.
      i_gpio[15] = 1'b1;
      repeat (4) tick();
      i_gpio[15] = 1'b0;
      tick();
      tick();
      wr(3'd7, 32'h0000_8000, 4'hF);
      check("collide_int0", 32'(o_int), 32'h1);
      rd(3'd7, 32'h0000_8000);
      check("collide_int1", 32'(o_int), 32'h1);
      wr(3'd6, 32'h0000_0000, 4'hF);
      rd(3'd7, 32'h0000_8000);
      wr(3'd7, 32'h0000_8000, 4'b0001);
      rd(3'd7, 32'h0000_8000);
      wr(3'd7, 32'h0000_8000, 4'b0010);
      tick();
      tick();
      check("int_cleared", 32'(o_int), 32'h0);
      rd(3'd7, 32'h0000_0000);

      // Pins high through reset: warm-up must suppress the false rising edges.
      rst = 1'b1;
      i_gpio = 16'hFFFF;
      repeat (3) tick();
      rst = 1'b0;
      wr(3'd5, 32'h0000_FFFF, 4'hF);
      repeat (6) tick();
      check("warm_int", 32'(o_int), 32'h0);
      check("warm_gpio", 32'(o_gpio), 32'h0000_00A5);
      rd(3'd7, 32'h0000_0000);
      rd(3'd0, 32'h0000_FFFF);

      // Four back-to-back strobes.
      wr(3'd4, 32'h0000_00C3, 4'hF);
      rd(3'd4, 32'h0000_00C3);
      rd(3'd0, 32'h0000_FFFF);
      wr(3'd7, 32'h0000_0001, 4'hF);
      tick();
      tick();
      check("oe_final", 32'(o_gpio_oe), 32'h0000_00C3);
      check("sb_drain", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
